// File: rtl/cuckoo_lookup.sv
`default_nettype none
//----------------------------------------------------------------------------
// cuckoo_lookup
// Lookup/delete engine for the two-table cuckoo store: probes table1, table2,
// then scans the stash in order, and clears the hit entry on a delete.
// Revision: 1.0
//----------------------------------------------------------------------------
module cuckoo_lookup #(
   parameter int DATA_W      = 32,
   parameter int IDX_W       = 5,
   parameter int STASH_DEPTH = 40,
   parameter int STASH_AW    = 6
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_op,
   input  logic [DATA_W-1:0]   req_key,
   input  logic [IDX_W-1:0]    req_index1,
   input  logic [IDX_W-1:0]    req_index2,
   output logic                rd_en,
   output logic                rd_sel,
   output logic [IDX_W-1:0]    rd_addr,
   input  logic [DATA_W-1:0]   rd_data,
   input  logic                rd_filled,
   output logic                stash_en,
   output logic [STASH_AW-1:0] stash_addr,
   input  logic [DATA_W-1:0]   stash_val,
   input  logic                stash_valid,
   output logic                clr_en,
   output logic                clr_sel,
   output logic [IDX_W-1:0]    clr_addr,
   output logic                stash_clr,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic                resp_hit,
   output logic [1:0]          resp_where,
   output logic [STASH_AW-1:0] resp_loc
);

   localparam logic [STASH_AW-1:0] c_LAST        = STASH_AW'(STASH_DEPTH - 1);
   localparam logic [1:0]          c_WHERE_NONE  = 2'd0;
   localparam logic [1:0]          c_WHERE_T1    = 2'd1;
   localparam logic [1:0]          c_WHERE_T2    = 2'd2;
   localparam logic [1:0]          c_WHERE_STASH = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T1   = 3'd1,
      S_T1C  = 3'd2,
      S_T2   = 3'd3,
      S_T2C  = 3'd4,
      S_SI   = 3'd5,
      S_SC   = 3'd6,
      S_RESP = 3'd7
   } state_t;

   state_t              state_q, state_d;
   logic                op_q, op_d;
   logic [DATA_W-1:0]   key_q, key_d;
   logic [IDX_W-1:0]    idx1_q, idx1_d;
   logic [IDX_W-1:0]    idx2_q, idx2_d;
   logic [STASH_AW-1:0] j_q, j_d;
   logic                hit_q, hit_d;
   logic [1:0]          where_q, where_d;
   logic [STASH_AW-1:0] loc_q, loc_d;
   logic                first_q, first_d;

   logic                w_tbl_match;
   logic                w_stash_match;

   // An unfilled table slot never matches, whatever stale data it returns.
   assign w_tbl_match   = rd_filled && (rd_data == key_q);
   assign w_stash_match = stash_valid && (stash_val == key_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= 1'b0;
         key_q   <= '0;
         idx1_q  <= '0;
         idx2_q  <= '0;
         j_q     <= '0;
         hit_q   <= 1'b0;
         where_q <= c_WHERE_NONE;
         loc_q   <= '0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         key_q   <= key_d;
         idx1_q  <= idx1_d;
         idx2_q  <= idx2_d;
         j_q     <= j_d;
         hit_q   <= hit_d;
         where_q <= where_d;
         loc_q   <= loc_d;
         first_q <= first_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      key_d   = key_q;
      idx1_d  = idx1_q;
      idx2_d  = idx2_q;
      j_d     = j_q;
      hit_d   = hit_q;
      where_d = where_q;
      loc_d   = loc_q;
      // first_q marks a delete hit during the first response cycle only.
      first_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               op_d    = req_op;
               key_d   = req_key;
               idx1_d  = req_index1;
               idx2_d  = req_index2;
               j_d     = '0;
               hit_d   = 1'b0;
               where_d = c_WHERE_NONE;
               loc_d   = '0;
               state_d = S_T1;
            end
         end
         S_T1: state_d = S_T1C;
         S_T1C: begin
            if (w_tbl_match) begin
               hit_d   = 1'b1;
               where_d = c_WHERE_T1;
               loc_d   = STASH_AW'(idx1_q);
               first_d = op_q;
               state_d = S_RESP;
            end else begin
               state_d = S_T2;
            end
         end
         S_T2: state_d = S_T2C;
         S_T2C: begin
            if (w_tbl_match) begin
               hit_d   = 1'b1;
               where_d = c_WHERE_T2;
               loc_d   = STASH_AW'(idx2_q);
               first_d = op_q;
               state_d = S_RESP;
            end else begin
               j_d     = '0;
               state_d = S_SI;
            end
         end
         S_SI: state_d = S_SC;
         S_SC: begin
            // The stash is kept contiguous, so the first empty entry ends the scan.
            if (!stash_valid) begin
               state_d = S_RESP;
            end else if (w_stash_match) begin
               hit_d   = 1'b1;
               where_d = c_WHERE_STASH;
               loc_d   = j_q;
               first_d = op_q;
               state_d = S_RESP;
            end else if (j_q == c_LAST) begin
               state_d = S_RESP;
            end else begin
               j_d     = j_q + 1'b1;
               state_d = S_SI;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               hit_d   = 1'b0;
               where_d = c_WHERE_NONE;
               loc_d   = '0;
               j_d     = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign resp_valid = (state_q == S_RESP);
   assign req_ready  = (state_q == S_IDLE) && !resp_valid;
   assign resp_hit   = hit_q;
   assign resp_where = where_q;
   assign resp_loc   = loc_q;

   assign rd_en      = (state_q == S_T1) || (state_q == S_T2);
   assign rd_sel     = (state_q == S_T2);
   assign rd_addr    = (state_q == S_T1) ? idx1_q :
                       (state_q == S_T2) ? idx2_q : '0;

   assign clr_en     = first_q && ((where_q == c_WHERE_T1) || (where_q == c_WHERE_T2));
   assign clr_sel    = clr_en && (where_q == c_WHERE_T2);
   assign clr_addr   = clr_en ? loc_q[IDX_W-1:0] : '0;
   assign stash_clr  = first_q && (where_q == c_WHERE_STASH);

   assign stash_en   = (state_q == S_SI);
   assign stash_addr = (stash_en || stash_clr) ? j_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_cuckoo_lookup.sv
`default_nettype none
//----------------------------------------------------------------------------
// tb_cuckoo_lookup
// Directed bench with a table/stash memory model and a reference lookup model.
// Revision: 1.0
//----------------------------------------------------------------------------
module tb_cuckoo_lookup;

   localparam int DW  = 32;
   localparam int IW  = 5;
   localparam int SD  = 40;
   localparam int SAW = 6;

   logic           clk;
   logic           reset;
   logic           req_valid, req_ready, req_op;
   logic [DW-1:0]  req_key;
   logic [IW-1:0]  req_index1, req_index2;
   logic           rd_en, rd_sel;
   logic [IW-1:0]  rd_addr;
   logic [DW-1:0]  rd_data;
   logic           rd_filled;
   logic           stash_en;
   logic [SAW-1:0] stash_addr;
   logic [DW-1:0]  stash_val;
   logic           stash_valid;
   logic           clr_en, clr_sel;
   logic [IW-1:0]  clr_addr;
   logic           stash_clr;
   logic           resp_valid, resp_ready, resp_hit;
   logic [1:0]     resp_where;
   logic [SAW-1:0] resp_loc;

   logic [DW-1:0]  t1 [0:31];
   logic           f1 [0:31];
   logic [DW-1:0]  t2 [0:31];
   logic           f2 [0:31];
   logic [DW-1:0]  st [0:SD-1];
   logic           sv [0:SD-1];

   int vectors     = 0;
   int miscompares = 0;
   int lat;

   cuckoo_lookup #(
      .DATA_W(DW), .IDX_W(IW), .STASH_DEPTH(SD), .STASH_AW(SAW)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_key(req_key), .req_index1(req_index1), .req_index2(req_index2),
      .rd_en(rd_en), .rd_sel(rd_sel), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_filled(rd_filled),
      .stash_en(stash_en), .stash_addr(stash_addr),
      .stash_val(stash_val), .stash_valid(stash_valid),
      .clr_en(clr_en), .clr_sel(clr_sel), .clr_addr(clr_addr),
      .stash_clr(stash_clr),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
      .resp_where(resp_where), .resp_loc(resp_loc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Registered read ports of the shared table and stash storage.
   always @(posedge clk) begin
      rd_data   <= rd_en ? (rd_sel ? t2[rd_addr] : t1[rd_addr]) : 32'h0BAD_F00D;
      rd_filled <= rd_en ? (rd_sel ? f2[rd_addr] : f1[rd_addr]) : 1'b0;
      if (stash_en && int'(stash_addr) < SD) begin
         stash_val   <= st[stash_addr];
         stash_valid <= sv[stash_addr];
      end else begin
         stash_val   <= 32'h0;
         stash_valid <= 1'b0;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic clear_all();
      for (int i = 0; i < 32; i++) begin
         t1[i] = 32'h0; f1[i] = 1'b0; t2[i] = 32'h0; f2[i] = 1'b0;
      end
      for (int i = 0; i < SD; i++) begin
         st[i] = 32'h0; sv[i] = 1'b0;
      end
   endtask

   // Where the key lives and how many cycles after acceptance the answer appears.
   function automatic void model(input logic [DW-1:0] key, input logic [IW-1:0] i1,
                                 input logic [IW-1:0] i2, output logic hit,
                                 output logic [1:0] where, output logic [SAW-1:0] loc,
                                 output int l);
      hit = 1'b0; where = 2'd0; loc = '0;
      if (f1[i1] && t1[i1] == key) begin
         hit = 1'b1; where = 2'd1; loc = SAW'(i1); l = 3; return;
      end
      if (f2[i2] && t2[i2] == key) begin
         hit = 1'b1; where = 2'd2; loc = SAW'(i2); l = 5; return;
      end
      for (int j = 0; j < SD; j++) begin
         if (!sv[j]) begin
            l = 7 + 2 * j; return;
         end
         if (st[j] == key) begin
            hit = 1'b1; where = 2'd3; loc = SAW'(j); l = 7 + 2 * j; return;
         end
      end
      l = 5 + 2 * SD;
   endfunction

   task automatic chk_idle(input string nm);
      chk({nm, "_outputs"}, {rd_en, rd_sel, rd_addr, stash_en, stash_addr, clr_en, clr_sel,
                             clr_addr, stash_clr, resp_valid, resp_hit, resp_where, resp_loc}, 0);
      chk({nm, "_req_ready"}, req_ready, 1);
   endtask

   // Cycle c is the clock period that follows edge k+c-1, k being the accept edge.
   task automatic run_req(input logic op, input logic [DW-1:0] key, input logic [IW-1:0] i1,
                          input logic [IW-1:0] i2, input int hold, output int lat_seen);
      logic           ehit;
      logic [1:0]     ew;
      logic [SAW-1:0] el;
      int             elat;
      logic [8:0]     snap;
      model(key, i1, i2, ehit, ew, el, elat);
      lat_seen = 0;
      @(negedge clk);
      chk("req_ready_idle", req_ready, 1);
      resp_ready = 1'b0;
      req_valid = 1'b1; req_op = op; req_key = key; req_index1 = i1; req_index2 = i2;
      @(posedge clk);
      #1;
      // A different request stays presented while busy and must be ignored.
      req_op = ~op; req_key = ~key; req_index1 = i1 + 1'b1; req_index2 = i2 + 1'b1;
      for (int c = 1; c <= elat; c++) begin
         @(negedge clk);
         chk("rd_en", rd_en, (c == 1) || (c == 3 && elat >= 5));
         if (rd_en) begin
            chk("rd_sel", rd_sel, c == 3);
            chk("rd_addr", rd_addr, (c == 3) ? i2 : i1);
         end
         chk("stash_en", stash_en, c >= 5 && c < elat && ((c - 5) % 2) == 0);
         if (stash_en) chk("stash_addr", stash_addr, (c - 5) / 2);
         chk("req_ready_busy", req_ready, 0);
         chk("resp_valid", resp_valid, c == elat);
         if (c != elat) chk("early_strobe", {clr_en, stash_clr}, 0);
         if (resp_valid && lat_seen == 0) lat_seen = c;
      end
      req_valid = 1'b0;
      chk("resp_hit", resp_hit, ehit);
      chk("resp_where", resp_where, ew);
      chk("resp_loc", resp_loc, el);
      chk("clr_en", clr_en, op && ehit && (ew == 2'd1 || ew == 2'd2));
      if (clr_en) begin
         chk("clr_sel", clr_sel, ew == 2'd2);
         chk("clr_addr", clr_addr, (ew == 2'd1) ? i1 : i2);
         if (clr_sel) f2[clr_addr] = 1'b0; else f1[clr_addr] = 1'b0;
      end
      chk("stash_clr", stash_clr, op && ehit && ew == 2'd3);
      if (stash_clr) begin
         chk("stash_clr_addr", stash_addr, el);
         if (int'(stash_addr) < SD) sv[stash_addr] = 1'b0;
      end
      snap = {resp_hit, resp_where, resp_loc};
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid", resp_valid, 1);
         chk("hold_fields", {resp_hit, resp_where, resp_loc}, snap);
         chk("hold_req_ready", req_ready, 0);
         chk("hold_strobes", {clr_en, stash_clr}, 0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      chk("after_hs_valid", resp_valid, 0);
      chk("after_hs_req_ready", req_ready, 1);
      chk("after_hs_strobes", {clr_en, stash_clr, rd_en, stash_en}, 0);
      for (int n = 0; n < 200 && !req_ready; n++) @(negedge clk);
      resp_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_key = '0;
      req_index1 = '0; req_index2 = '0; resp_ready = 1'b0;
      clear_all();
      @(negedge clk);
      chk_idle("reset");
      reset = 1'b0;
      @(negedge clk);
      chk_idle("post_reset");

      // table1 hit
      t1[3] = 32'hDEADBEEF; f1[3] = 1'b1;
      run_req(1'b0, 32'hDEADBEEF, 5'd3, 5'd7, 0, lat);
      chk("lat_t1_hit", lat, 3);

      // table2 hit with delete, then the cleared entry is gone
      t1[3] = 32'h1; t2[9] = 32'hDEADBEEF; f2[9] = 1'b1;
      run_req(1'b1, 32'hDEADBEEF, 5'd3, 5'd9, 0, lat);
      chk("lat_t2_del", lat, 5);
      chk("t2_entry_cleared", f2[9], 0);
      run_req(1'b0, 32'hDEADBEEF, 5'd3, 5'd9, 0, lat);
      chk("lat_miss_empty_stash", lat, 7);

      // stash hit at entry 4; table1 holds a one-bit-off copy of the key
      clear_all();
      for (int j = 0; j < 5; j++) begin st[j] = 32'h1000 + j; sv[j] = 1'b1; end
      st[4] = 32'hCAFEF00D;
      t1[2] = 32'h4AFEF00D; f1[2] = 1'b1; f2[4] = 1'b1;
      run_req(1'b0, 32'hCAFEF00D, 5'd2, 5'd4, 0, lat);
      chk("lat_stash4", lat, 15);
      run_req(1'b1, 32'hCAFEF00D, 5'd2, 5'd4, 0, lat);
      chk("lat_stash4_del", lat, 15);
      chk("stash4_cleared", sv[4], 0);

      // miss, two stash entries occupied (delete miss: no strobes)
      clear_all();
      sv[0] = 1'b1; sv[1] = 1'b1; st[0] = 32'h11; st[1] = 32'h22;
      run_req(1'b1, 32'h12345678, 5'd0, 5'd31, 0, lat);
      chk("lat_miss_n2", lat, 11);

      // miss, stash completely full
      for (int j = 0; j < SD; j++) begin st[j] = 32'hA000 + j; sv[j] = 1'b1; end
      run_req(1'b0, 32'h12345678, 5'd1, 5'd2, 0, lat);
      chk("lat_miss_full", lat, 85);

      // filled=0 in table1 must not match; table2 hit instead
      clear_all();
      t1[5] = 32'h600DCAFE; f1[5] = 1'b0; t2[6] = 32'h600DCAFE; f2[6] = 1'b1;
      run_req(1'b0, 32'h600DCAFE, 5'd5, 5'd6, 0, lat);
      chk("lat_unfilled_t1", lat, 5);

      // response held for 4 cycles
      t1[31] = 32'hFFFFFFFF; f1[31] = 1'b1;
      run_req(1'b1, 32'hFFFFFFFF, 5'd31, 5'd0, 4, lat);
      chk("lat_hold", lat, 3);

      // asynchronous reset in the middle of a stash scan
      clear_all();
      for (int j = 0; j < 10; j++) begin st[j] = 32'h700 + j; sv[j] = 1'b1; end
      @(negedge clk);
      req_valid = 1'b1; req_op = 1'b1; req_key = 32'h5555AAAA;
      req_index1 = 5'd0; req_index2 = 5'd0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (7) @(negedge clk);
      chk("scan_active", stash_en, 1);
      #2 reset = 1'b1;
      #1 chk_idle("async_reset");
      @(posedge clk);
      #1 chk_idle("in_reset");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk_idle("after_reset");
      t1[4] = 32'h5555AAAA; f1[4] = 1'b1;
      run_req(1'b0, 32'h5555AAAA, 5'd4, 5'd0, 0, lat);
      chk("lat_after_reset", lat, 3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
